// File: rtl/sd_data_master.sv
// SD data-path master: sequences one block transfer between FIFOs and
// serial host, aborting on FIFO errors and latching sticky status bits.
// Ports: sd_clk/rst, start_tx_i/start_rx_i requests, d_write_o/d_read_o
// host strobes, FIFO enables and flags, xfr_complete_i/crc_ok_i from the
// host, int_status_o sticky status with int_status_rst_i clear.
module sd_data_master #(
  parameter int INT_DATA_SIZE = 3
) (
  input  logic                     sd_clk,
  input  logic                     rst,
  input  logic                     start_tx_i,
  input  logic                     start_rx_i,
  output logic                     d_write_o,
  output logic                     d_read_o,
  output logic                     start_tx_fifo_o,
  output logic                     start_rx_fifo_o,
  input  logic                     tx_fifo_empty_i,
  input  logic                     tx_fifo_full_i,
  input  logic                     rx_fifo_full_i,
  input  logic                     xfr_complete_i,
  input  logic                     crc_ok_i,
  output logic [INT_DATA_SIZE-1:0] int_status_o,
  input  logic                     int_status_rst_i
);

  typedef enum logic [2:0] {
    IDLE,
    TX_FILL,
    XFER_START,
    XFER_WAIT_BUSY,
    XFER_BUSY,
    ABORT
  } state_t;

  state_t state, state_n;
  logic   dir_tx, dir_tx_n;
  logic   wr_n, rd_n, txf_n, rxf_n;
  logic   fifo_err;
  logic [INT_DATA_SIZE-1:0] set_v;
  logic [INT_DATA_SIZE-1:0] status_n;

  // Only the FIFO feeding the active direction can fault.
  assign fifo_err = dir_tx ? tx_fifo_empty_i : rx_fifo_full_i;

  always_comb begin
    state_n  = state;
    dir_tx_n = dir_tx;
    wr_n     = 1'b0;
    rd_n     = 1'b0;
    txf_n    = start_tx_fifo_o;
    rxf_n    = start_rx_fifo_o;
    set_v    = '0;
    unique case (state)
      IDLE: begin
        txf_n = 1'b0;
        rxf_n = 1'b0;
        if (start_tx_i) begin
          state_n  = TX_FILL;
          dir_tx_n = 1'b1;
          txf_n    = 1'b1;
        end else if (start_rx_i && xfr_complete_i) begin
          state_n  = XFER_START;
          dir_tx_n = 1'b0;
          rxf_n    = 1'b1;
          rd_n     = 1'b1;
        end
      end
      TX_FILL: begin
        txf_n = 1'b1;
        if (tx_fifo_full_i && xfr_complete_i) begin
          state_n = XFER_START;
          wr_n    = 1'b1;
        end
      end
      XFER_START, XFER_WAIT_BUSY, XFER_BUSY: begin
        // A FIFO fault beats a completion seen in the same cycle.
        if (fifo_err) begin
          state_n  = ABORT;
          wr_n     = 1'b1;
          rd_n     = 1'b1;
          txf_n    = 1'b0;
          rxf_n    = 1'b0;
          set_v[2] = 1'b1;
        end else if (state == XFER_START) begin
          state_n = XFER_WAIT_BUSY;
        end else if (state == XFER_WAIT_BUSY) begin
          if (!xfr_complete_i) state_n = XFER_BUSY;
        end else if (xfr_complete_i) begin
          state_n = IDLE;
          txf_n   = 1'b0;
          rxf_n   = 1'b0;
          if (crc_ok_i) set_v[0] = 1'b1;
          else          set_v[1] = 1'b1;
        end
      end
      ABORT: begin
        txf_n = 1'b0;
        rxf_n = 1'b0;
        if (xfr_complete_i) begin
          state_n = IDLE;
        end else begin
          wr_n = 1'b1;
          rd_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        txf_n   = 1'b0;
        rxf_n   = 1'b0;
      end
    endcase
    // Set events override a clear in the same cycle.
    status_n = (int_status_rst_i ? '0 : int_status_o) | set_v;
  end

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      dir_tx          <= 1'b0;
      d_write_o       <= 1'b0;
      d_read_o        <= 1'b0;
      start_tx_fifo_o <= 1'b0;
      start_rx_fifo_o <= 1'b0;
      int_status_o    <= '0;
    end else begin
      state           <= state_n;
      dir_tx          <= dir_tx_n;
      d_write_o       <= wr_n;
      d_read_o        <= rd_n;
      start_tx_fifo_o <= txf_n;
      start_rx_fifo_o <= rxf_n;
      int_status_o    <= status_n;
    end
  end

endmodule

// File: tb/tb_sd_data_master.sv
// Self-checking bench for sd_data_master: scenario tasks with randomized
// timing, checked against a transaction-level model of the status word.
module tb_sd_data_master;

  logic       sd_clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_tx = 1'b0;
  logic       start_rx = 1'b0;
  logic       d_write_o, d_read_o;
  logic       start_tx_fifo_o, start_rx_fifo_o;
  logic       tx_empty = 1'b0;
  logic       tx_full = 1'b0;
  logic       rx_full = 1'b0;
  logic       complete = 1'b1;
  logic       crc_ok = 1'b0;
  logic [2:0] int_status_o;
  logic       st_clr = 1'b0;

  int         errors = 0;
  int         checks = 0;
  logic [2:0] exp_st = 3'b000;

  always #5 sd_clk = ~sd_clk;

  sd_data_master #(.INT_DATA_SIZE(3)) dut (
    .sd_clk           (sd_clk),
    .rst              (rst),
    .start_tx_i       (start_tx),
    .start_rx_i       (start_rx),
    .d_write_o        (d_write_o),
    .d_read_o         (d_read_o),
    .start_tx_fifo_o  (start_tx_fifo_o),
    .start_rx_fifo_o  (start_rx_fifo_o),
    .tx_fifo_empty_i  (tx_empty),
    .tx_fifo_full_i   (tx_full),
    .rx_fifo_full_i   (rx_full),
    .xfr_complete_i   (complete),
    .crc_ok_i         (crc_ok),
    .int_status_o     (int_status_o),
    .int_status_rst_i (st_clr)
  );

  // {d_write, d_read, tx_fifo_en, rx_fifo_en, status}
  function automatic logic [6:0] outs();
    return {d_write_o, d_read_o, start_tx_fifo_o,
            start_rx_fifo_o, int_status_o};
  endfunction

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  // One transfer. err < busy injects a fault in busy cycle err.
  task automatic do_xfer(input bit tx, input int fill, input int busy,
                         input bit crc, input int err, input bit clr_end);
    logic [6:0] e;
    bit cc;
    int h;
    if (tx) start_tx = 1'b1;
    else    start_rx = 1'b1;
    tick();
    start_tx = 1'b0;
    start_rx = 1'b0;
    e = {1'b0, !tx, tx, !tx, exp_st};
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL start obs=%b exp=%b", outs(), e);
    end
    if (tx) begin
      for (int i = 0; i < fill; i++) begin
        tick();
        e = {4'b0010, exp_st};
        checks++;
        if (outs() !== e) begin
          errors++;
          $display("FAIL tx_fill obs=%b exp=%b", outs(), e);
        end
      end
      tx_full = 1'b1;
      tick();
      tx_full = 1'b0;
      e = {4'b1010, exp_st};
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL write_pulse obs=%b exp=%b", outs(), e);
      end
    end
    tick();
    e = {2'b00, tx, !tx, exp_st};
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL pulse_end obs=%b exp=%b", outs(), e);
    end
    complete = 1'b0;
    tick();
    for (int i = 0; i < busy; i++) begin
      if (i == err) begin
        cc = 1'($urandom_range(0, 1));
        if (tx) tx_empty = 1'b1;
        else    rx_full = 1'b1;
        if (cc) begin
          complete = 1'b1;
          crc_ok = 1'b1;
        end
        tick();
        tx_empty = 1'b0;
        rx_full = 1'b0;
        crc_ok = 1'b0;
        exp_st = exp_st | 3'b100;
        e = {4'b1100, exp_st};
        checks++;
        if (outs() !== e) begin
          errors++;
          $display("FAIL abort obs=%b exp=%b", outs(), e);
        end
        if (!cc) begin
          h = $urandom_range(1, 3);
          for (int j = 0; j < h; j++) begin
            tick();
            checks++;
            if (outs() !== e) begin
              errors++;
              $display("FAIL abort_hold obs=%b exp=%b", outs(), e);
            end
          end
          complete = 1'b1;
        end
        tick();
        e = {4'b0000, exp_st};
        checks++;
        if (outs() !== e) begin
          errors++;
          $display("FAIL abort_exit obs=%b exp=%b", outs(), e);
        end
        return;
      end
      if (i == busy / 2) begin
        // wrong-direction flag and stray starts must be ignored
        if (tx) rx_full = 1'b1;
        else    tx_empty = 1'b1;
        start_tx = 1'b1;
        start_rx = 1'b1;
      end
      tick();
      rx_full = 1'b0;
      tx_empty = 1'b0;
      start_tx = 1'b0;
      start_rx = 1'b0;
      e = {2'b00, tx, !tx, exp_st};
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL busy obs=%b exp=%b", outs(), e);
      end
    end
    complete = 1'b1;
    crc_ok = crc;
    st_clr = clr_end;
    tick();
    crc_ok = 1'b0;
    st_clr = 1'b0;
    exp_st = (clr_end ? 3'b000 : exp_st) | (crc ? 3'b001 : 3'b010);
    e = {4'b0000, exp_st};
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL done obs=%b exp=%b", outs(), e);
    end
  endtask

  task automatic clear_status();
    st_clr = 1'b1;
    tick();
    st_clr = 1'b0;
    exp_st = 3'b000;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL clear obs=%b exp=%b", outs(), 7'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs() !== 7'b0) begin
        errors++;
        $display("FAIL reset obs=%b exp=%b", outs(), 7'b0);
      end
    end
  endtask

  task automatic test_tx_ok();
    do_xfer(1'b1, 2, 12, 1'b1, 99, 1'b0);
    clear_status();
  endtask

  task automatic test_rx_ok();
    do_xfer(1'b0, 0, 12, 1'b1, 99, 1'b0);
    clear_status();
  endtask

  task automatic test_crc_fail();
    do_xfer(1'b1, 1, 12, 1'b0, 99, 1'b0);
    clear_status();
    do_xfer(1'b0, 0, 12, 1'b0, 99, 1'b0);
    clear_status();
  endtask

  task automatic test_tx_underrun();
    do_xfer(1'b1, 0, 8, 1'b1, 4, 1'b0);
  endtask

  task automatic test_rx_overrun();
    clear_status();
    do_xfer(1'b0, 0, 8, 1'b1, 3, 1'b0);
    clear_status();
  endtask

  task automatic test_set_beats_clear();
    do_xfer(1'b0, 0, 3, 1'b0, 99, 1'b0);
    do_xfer(1'b1, 0, 3, 1'b1, 99, 1'b1);
    clear_status();
  endtask

  task automatic test_start_gating();
    // rx needs an idle host
    complete = 1'b0;
    start_rx = 1'b1;
    tick();
    start_rx = 1'b0;
    complete = 1'b1;
    checks++;
    if (outs() !== {4'b0000, exp_st}) begin
      errors++;
      $display("FAIL rx_gate obs=%b exp=%b", outs(), {4'b0000, exp_st});
    end
    // tx wins when both are requested
    start_rx = 1'b1;
    do_xfer(1'b1, 1, 4, 1'b1, 99, 1'b0);
    clear_status();
  endtask

  task automatic test_mid_reset();
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    tx_full = 1'b1;
    tick();
    tx_full = 1'b0;
    tick();
    complete = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=%b", outs(), 7'b0);
    end
    tick();
    rst = 1'b1;
    complete = 1'b1;
    crc_ok = 1'b1;
    tick();
    tick();
    crc_ok = 1'b0;
    exp_st = 3'b000;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL post_reset obs=%b exp=%b", outs(), 7'b0);
    end
  endtask

  task automatic test_random();
    bit tx;
    int busy;
    int err;
    for (int n = 0; n < 40; n++) begin
      tx = 1'($urandom_range(0, 1));
      busy = $urandom_range(1, 10);
      err = ($urandom_range(0, 3) == 0) ? $urandom_range(0, busy - 1) : 99;
      do_xfer(tx, $urandom_range(0, 3), busy, 1'($urandom_range(0, 1)),
              err, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 3) == 0) clear_status();
    end
  endtask

  initial begin
    test_reset();
    test_tx_ok();
    test_rx_ok();
    test_crc_fail();
    test_tx_underrun();
    test_rx_overrun();
    test_set_beats_clear();
    test_start_gating();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_data_master.md
Name: sd_data_master

Overview:
- Control FSM for the SD card data path. Sits between the register/bus side, the TX/RX data FIFOs and the serial data host.
- Sequences each block transfer:
  - enables the relevant FIFO;
  - issues a one-cycle write/read start pulse to the serial host;
  - tracks the host's completion and CRC result;
  - detects FIFO under/overrun and aborts the host.
- Reports results in a sticky interrupt-status vector.

Parameters:
- INT_DATA_SIZE, default 3: width of int_status_o. Bit 0 = transfer completed OK, bit 1 = CRC error, bit 2 = FIFO underrun/overrun. Bits above 2 read 0.

Ports:
- sd_clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_tx_i  in  1  request a card-write transfer (fill TX FIFO, then send).
- start_rx_i  in  1  request a card-read transfer.
- d_write_o  out  1  to serial host: start write (one-cycle pulse); held high together with d_read_o to abort.
- d_read_o  out  1  to serial host: start read (one-cycle pulse); held high together with d_write_o to abort.
- start_tx_fifo_o  out  1  TX FIFO enable/fill.
- start_rx_fifo_o  out  1  RX FIFO enable.
- tx_fifo_empty_i  in  1  TX FIFO empty (underrun when seen during a transfer).
- tx_fifo_full_i  in  1  TX FIFO full (ready to send).
- rx_fifo_full_i  in  1  RX FIFO full (overrun when seen during a transfer).
- xfr_complete_i  in  1  serial host idle; 0 while busy; stays 1 after finishing.
- crc_ok_i  in  1  CRC result; valid in the cycle xfr_complete_i rises.
- int_status_o  out  INT_DATA_SIZE  sticky status bits.
- int_status_rst_i  in  1  synchronous clear of int_status_o.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE;
  - all outputs 0;
  - int_status_o = 0.
- All outputs are registered and update on the same edge as the state change.
- Transfer direction register: tx or rx, latched on leaving IDLE.
- IDLE:
  - all control outputs 0.
  - start_tx_i=1 → TX_FILL, start_tx_fifo_o=1.
  - Otherwise start_rx_i=1 and xfr_complete_i=1 → XFER_START, start_rx_fifo_o=1, d_read_o=1.
  - If both starts are high, tx wins.
  - Start requests arriving outside IDLE are ignored.
- TX_FILL:
  - start_tx_fifo_o=1.
  - When tx_fifo_full_i=1 and xfr_complete_i=1 → XFER_START with d_write_o=1.
- XFER_START:
  - lasts one cycle; the d_write_o/d_read_o pulse is exactly one cycle wide.
  - Next state XFER_WAIT_BUSY; pulse deasserted.
  - FIFO-enable output stays 1.
- XFER_WAIT_BUSY:
  - wait for xfr_complete_i=0, then → XFER_BUSY.
- XFER_BUSY:
  - when xfr_complete_i=1 → IDLE, clearing the FIFO enables.
  - Same edge: if crc_ok_i=1 set int_status[0], else set int_status[1].
- FIFO error:
  - Applies in XFER_START, XFER_WAIT_BUSY and XFER_BUSY.
  - Condition: tx direction with tx_fifo_empty_i=1, or rx direction with rx_fifo_full_i=1.
  - Action → ABORT, set int_status[2].
  - Error takes priority over completion in the same cycle.
- ABORT:
  - d_write_o=1, d_read_o=1, both FIFO enables 0, held.
  - When xfr_complete_i=1 → IDLE.
- int_status_o:
  - bits are sticky until int_status_rst_i=1, which clears all bits at the next edge.
  - A set event in the same cycle as a clear wins (that bit ends up 1).
- Reset mid-transfer aborts immediately to IDLE; no status is set.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release; for 3 more cycles d_write_o, d_read_o, start_tx_fifo_o, start_rx_fifo_o all 0 and int_status_o=0.
- TX OK:
  - Stimulus: start_tx_i 1-cycle pulse → start_tx_fifo_o=1 with others 0. Then tx_fifo_full_i=1 (xfr_complete_i=1) → d_write_o=1 for one cycle. Host drops xfr_complete_i; 12 cycles later raise it with crc_ok_i=1.
  - Response: start_tx_fifo_o→0, int_status_o=1. int_status_rst_i pulse → 0.
- RX OK: start_rx_i pulse → start_rx_fifo_o=1 and d_read_o=1 together, d_read_o low within 2 cycles; completion with crc_ok_i=1 → start_rx_fifo_o→0, int_status_o=1.
- CRC fail, both directions: same sequences as TX OK and RX OK with crc_ok_i=0 → int_status_o=2 (bit 0 clear).
- TX underrun: during busy, a 1-cycle tx_fifo_empty_i pulse → next cycle d_write_o=d_read_o=1, start_tx_fifo_o=0, int_status_o=4. Raising xfr_complete_i → IDLE with outputs 0.
- RX overrun: during busy, a 1-cycle rx_fifo_full_i pulse → d_write_o=d_read_o=1, start_rx_fifo_o=0, int_status_o=4. Clear via int_status_rst_i → 0.
